// File: rtl/alu_pkg.sv
// Shared opcode encoding and the XLEN-agnostic ALU function for the elastic ALU pipeline.
// Operands are passed zero-extended to ALU_MAX_W bits; the caller truncates the result to XLEN.
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpSll  = 4'd5,
        OpSrl  = 4'd6,
        OpSra  = 4'd7,
        OpSlt  = 4'd8,
        OpSltu = 4'd9
    } alu_op_e;

    localparam int unsigned ALU_OP_LAST = 9;
    localparam int unsigned ALU_MAX_W   = 64;

    function automatic logic alu_op_legal(input logic [3:0] op);
        return op <= 4'(ALU_OP_LAST);
    endfunction

    function automatic logic [ALU_MAX_W-1:0] alu_compute(
        input logic [3:0]           op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input int unsigned          xlen
    );
        logic [ALU_MAX_W-1:0] a_sx;
        logic [ALU_MAX_W-1:0] b_sx;
        logic [ALU_MAX_W-1:0] res;
        logic [5:0]           shamt;
        int unsigned          pad;
        pad   = ALU_MAX_W - xlen;
        // Re-sign-extend from bit xlen-1 for the signed ops.
        a_sx  = $signed(a << pad) >>> pad;
        b_sx  = $signed(b << pad) >>> pad;
        shamt = b[5:0] & 6'(xlen - 1);
        res   = '0;
        case (op)
            OpAdd:   res = a + b;
            OpSub:   res = a - b;
            OpAnd:   res = a & b;
            OpOr:    res = a | b;
            OpXor:   res = a ^ b;
            OpSll:   res = a << shamt;
            OpSrl:   res = a >> shamt;
            OpSra:   res = $signed(a_sx) >>> shamt;
            OpSlt:   res = ALU_MAX_W'($signed(a_sx) < $signed(b_sx));
            OpSltu:  res = ALU_MAX_W'(a < b);
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_pipe_slice.sv
// One elastic pipeline register: loads when empty or when its content is being taken downstream.
// Flush clears the valid bit; payload holds its last value.
module alu_pipe_slice #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    always_comb begin
        load    = !valid_q || out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/alu_pipe_elastic.sv
// Elastic ALU pipeline: compute on accept into stage 0, then STAGES-1 carry-only slices.
// Ready is derived per stage from the valid bits directly so there is no combinational chain.
module alu_pipe_elastic
    import alu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);

    localparam int unsigned PW = XLEN + TAG_W + 1;

    logic                        legal;
    logic [XLEN-1:0]             s0_result;
    logic [PW-1:0]               s0_data;
    logic [STAGES-1:0]           stage_v;
    logic [STAGES-1:0]           down_rdy;
    logic [STAGES-1:0][PW-1:0]   pay;

    assign legal     = alu_op_legal(in_op);
    assign s0_result = XLEN'(alu_compute(in_op, ALU_MAX_W'(in_a), ALU_MAX_W'(in_b), XLEN));
    assign s0_data   = {~legal, in_tag, s0_result};

    // Stage i may move when out_ready or any later stage is empty (bubbles collapse).
    always_comb begin
        down_rdy = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            down_rdy[i] = out_ready;
            for (int unsigned j = i + 1; j < STAGES; j++) begin
                down_rdy[i] = down_rdy[i] | ~stage_v[j];
            end
        end
    end

    assign in_ready = rst_n && !flush && (!stage_v[0] || down_rdy[0]);

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic          v_in;
        logic [PW-1:0] d_in;
        if (i == 0) begin : g_head
            assign v_in = in_valid && in_ready;
            assign d_in = s0_data;
        end else begin : g_body
            assign v_in = stage_v[i-1];
            assign d_in = pay[i-1];
        end
        alu_pipe_slice #(
            .W(PW)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (v_in),
            .in_data   (d_in),
            .out_valid (stage_v[i]),
            .out_ready (down_rdy[i]),
            .out_data  (pay[i])
        );
    end

    assign out_valid                           = stage_v[STAGES-1];
    assign {out_illegal, out_tag, out_result}  = pay[STAGES-1];
    assign busy                                = |stage_v;

endmodule

// File: tb/tb_alu_pipe_elastic.sv
// Scoreboard bench for alu_pipe_elastic (XLEN=32, STAGES=3, TAG_W=4).
// Driver pushes hand-computed expectations on accept; a monitor pops on every output handshake.
module tb_alu_pipe_elastic;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_illegal;
    logic        busy;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_pipe_elastic #(
        .XLEN   (32),
        .STAGES (3),
        .TAG_W  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: samples mid-low-phase, after the driver has settled its inputs.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got result %h tag %h, expected none",
                         out_result, out_tag);
            end else begin
                mon_e = sb.pop_front();
                chk("result", out_result, mon_e.res);
                chk("tag", {28'd0, out_tag}, {28'd0, mon_e.tag});
                chk("illegal", {31'd0, out_illegal}, {31'd0, mon_e.ill});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] res, input logic ill);
        bit done = 0;
        bit r;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = op;
            in_a     = a;
            in_b     = b;
            in_tag   = tag;
            #1;
            r = in_ready;
            @(posedge clk);
            if (r) begin
                sb.push_back('{res, tag, ill});
                done = 1;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
        #3;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    logic [31:0] bp_a   [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    logic [31:0] bp_res [5] = '{32'd101, 32'd102, 32'd103, 32'd104, 32'd105};

    initial begin
        int acc;
        int k;
        bit r;

        // Reset state
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency: ADD 5+7 tag 3, out_valid exactly 3 cycles after accept
        send(4'd0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
        idle();
        #3 chk("lat_c1_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #3 chk("lat_c2_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #3 chk("lat_c3_out_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Op coverage, back-to-back
        send(4'd1, 32'h0000_0000, 32'h0000_0001, 4'd1, 32'hFFFF_FFFF, 1'b0);
        send(4'd7, 32'h8000_0000, 32'h0000_0021, 4'd2, 32'hC000_0000, 1'b0);
        send(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 32'h0000_0001, 1'b0);
        send(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 32'h0000_0000, 1'b0);
        send(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd5, 32'h00F0_00F0, 1'b0);
        send(4'd3, 32'h1234_0000, 32'h0000_5678, 4'd6, 32'h1234_5678, 1'b0);
        send(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd7, 32'hF0F0_0F0F, 1'b0);
        send(4'd5, 32'h0000_0001, 32'h0000_001F, 4'd8, 32'h8000_0000, 1'b0);
        send(4'd6, 32'h8000_0000, 32'h0000_0024, 4'd9, 32'h0800_0000, 1'b0);
        send(4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 4'd10, 32'h0000_0001, 1'b0);
        idle();
        drain();

        // Back-pressure: 5 offered, exactly 3 accepted
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = 4'd0;
            in_a     = bp_a[k];
            in_b     = 32'd100;
            in_tag   = 4'(8 + k);
            #1;
            r = in_ready;
            @(posedge clk);
            if (r) begin
                sb.push_back('{bp_res[k], 4'(8 + k), 1'b0});
                acc++;
                k++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_result", out_result, 32'd101);
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Full pipe: out_ready=1 opens in_ready in the same cycle
        @(negedge clk);
        out_ready = 1'b0;
        send(4'd0, 32'd10, 32'd1, 4'd1, 32'd11, 1'b0);
        send(4'd0, 32'd20, 32'd1, 4'd2, 32'd21, 1'b0);
        send(4'd0, 32'd30, 32'd1, 4'd3, 32'd31, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("full_in_ready_stall", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1 chk("full_in_ready_go", {31'd0, in_ready}, 32'd1);
        drain();

        // Flush with an op offered in the flush cycle
        @(negedge clk);
        out_ready = 1'b0;
        send(4'd0, 32'd1, 32'd1, 4'd1, 32'd2, 1'b0);
        send(4'd0, 32'd2, 32'd2, 4'd2, 32'd4, 1'b0);
        send(4'd0, 32'd3, 32'd3, 4'd3, 32'd6, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_a     = 32'd9;
        in_b     = 32'd9;
        in_tag   = 4'd15;
        flush    = 1'b1;
        #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        sb.delete();
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1 chk("flush_busy_later", {31'd0, busy}, 32'd0);

        // Illegal opcode followed by a legal op
        send(4'd12, 32'd1, 32'd1, 4'd5, 32'd0, 1'b1);
        send(4'd0, 32'd2, 32'd3, 4'd6, 32'd5, 1'b0);
        idle();
        drain();

        // Asynchronous reset mid-stream
        @(negedge clk);
        out_ready = 1'b0;
        send(4'd0, 32'd7, 32'd7, 4'd1, 32'd14, 1'b0);
        send(4'd0, 32'd8, 32'd8, 4'd2, 32'd16, 1'b0);
        send(4'd0, 32'd9, 32'd9, 4'd3, 32'd18, 1'b0);
        idle();
        #1 chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        #1 chk("rel_busy", {31'd0, busy}, 32'd0);
        send(4'd1, 32'd50, 32'd8, 4'd9, 32'd42, 1'b0);
        idle();
        drain();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1);
    end

endmodule
